// File: rtl/mem_pkg.sv
// Shared line format and responder state encoding, used by both the data
// cache and the main-memory line server so the two ends agree on layout.
package mem_pkg;
  localparam int WORD_W         = 32;
  localparam int DEF_LINE_WORDS = 4;

  typedef logic [WORD_W*DEF_LINE_WORDS-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } dmem_state_t;
endpackage

// File: rtl/dmem_line_array.sv
// Single-port synchronous line store: registered read of i_index every cycle,
// write-before-nothing (old data appears on o_rdata during a write edge).
module dmem_line_array #(
  parameter int LINE_W = 128,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic              i_clock,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_index,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] o_rdata
);
  logic [LINE_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_we) r_mem[i_index] <= i_wdata;
    o_rdata <= r_mem[i_index];
  end
endmodule

// File: rtl/dmem_line_server.sv
// Main-memory line responder for data-cache refills/writebacks with a fixed
// access latency. Optional statistics ports: define DMEM_LINE_SERVER_STATS_EN.
//
// state | meaning
// IDLE  | ready for a request
// BUSY  | latency countdown; array access on the terminal count
// RESP  | response held until the cache takes it
module dmem_line_server
  import mem_pkg::*;
#(
  parameter int LINE_WORDS  = DEF_LINE_WORDS,
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 5
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic                         i_req_we,
  input  logic [31:0]                  i_req_addr,
  input  logic [WORD_W*LINE_WORDS-1:0] i_req_wdata,
  output logic                         o_resp_valid,
  input  logic                         i_resp_ready,
  output logic                         o_resp_is_write,
  output logic [WORD_W*LINE_WORDS-1:0] o_resp_rdata
`ifdef DMEM_LINE_SERVER_STATS_EN
  ,
  output logic [31:0]                  o_stat_reads,
  output logic [31:0]                  o_stat_writes,
  output logic [31:0]                  o_stat_backpressure
`endif
);
  localparam int LINE_W = WORD_W * LINE_WORDS;
  localparam int IDX_W  = $clog2(DEPTH_LINES);
  localparam int OFS    = $clog2(4 * LINE_WORDS);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("dmem_line_server: LATENCY must be in 1..255");
  end
  if ((1 << IDX_W) != DEPTH_LINES) begin : g_bad_depth
    $error("dmem_line_server: DEPTH_LINES must be a power of two");
  end

  dmem_state_t       r_state, w_state_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic              r_we;
  logic [IDX_W-1:0]  r_idx;
  logic [LINE_W-1:0] r_wdata;
  logic              r_resp_is_write;
  logic [LINE_W-1:0] r_resp_rdata;

  logic              w_accept, w_done, w_arr_we;
  logic [IDX_W-1:0]  w_req_idx, w_arr_idx;
  logic [LINE_W-1:0] w_arr_rdata;
  logic              w_unused_addr;

  assign w_req_idx     = i_req_addr[OFS +: IDX_W];
  assign w_unused_addr = ^{i_req_addr[31:OFS+IDX_W], i_req_addr[OFS-1:0]};

  assign o_req_ready     = (r_state == IDLE) && !i_reset;
  assign o_resp_valid    = (r_state == RESP);
  assign o_resp_is_write = r_resp_is_write;
  assign o_resp_rdata    = r_resp_rdata;

  // Address the request index while idle so the read is already under way
  // at the accept edge; that is what makes LATENCY=1 reach the array in time.
  assign w_arr_idx = (r_state == IDLE) ? w_req_idx : r_idx;
  assign w_arr_we  = w_done && r_we && !i_reset;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req_valid && o_req_ready) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = 8'(LATENCY - 1);
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == 8'd0) begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      RESP: begin
        if (i_resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state         <= IDLE;
      r_cnt           <= 8'd0;
      r_we            <= 1'b0;
      r_idx           <= '0;
      r_wdata         <= '0;
      r_resp_is_write <= 1'b0;
      r_resp_rdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we    <= i_req_we;
        r_idx   <= w_req_idx;
        r_wdata <= i_req_wdata;
      end
      if (w_done) begin
        r_resp_is_write <= r_we;
        r_resp_rdata    <= r_we ? '0 : w_arr_rdata;
      end
    end
  end

  dmem_line_array #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH_LINES),
    .IDX_W  (IDX_W)
  ) u_array (
    .i_clock (i_clock),
    .i_we    (w_arr_we),
    .i_index (w_arr_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_arr_rdata)
  );

`ifdef DMEM_LINE_SERVER_STATS_EN
  logic [31:0] r_stat_reads, r_stat_writes, r_stat_bp;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_stat_reads  <= '0;
      r_stat_writes <= '0;
      r_stat_bp     <= '0;
    end else begin
      if (w_accept && !i_req_we && r_stat_reads != '1)  r_stat_reads  <= r_stat_reads + 32'd1;
      if (w_accept && i_req_we && r_stat_writes != '1)  r_stat_writes <= r_stat_writes + 32'd1;
      if (o_resp_valid && !i_resp_ready && r_stat_bp != '1) r_stat_bp <= r_stat_bp + 32'd1;
    end
  end

  assign o_stat_reads        = r_stat_reads;
  assign o_stat_writes       = r_stat_writes;
  assign o_stat_backpressure = r_stat_bp;
`endif
endmodule

// File: tb/tb_dmem_line_server.sv
// Scoreboard bench for dmem_line_server: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever a response appears.
module tb_dmem_line_server;
  import mem_pkg::*;

  localparam int LAT = 5;

  typedef struct {
    logic        we;
    logic        chk_data;
    line_t       data;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  line_t       req_wdata;
  logic        resp_valid, resp_ready, resp_is_write;
  line_t       resp_rdata;
`ifdef DMEM_LINE_SERVER_STATS_EN
  logic [31:0] stat_reads, stat_writes, stat_bp;
`endif

  exp_t        q[$];
  exp_t        cur;
  logic        have_cur, prev_valid, prev_hs;
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_mis = 0;
  int unsigned m_reads, m_writes, m_bp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_line_server #(.LATENCY(LAT)) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_we        (req_we),
    .i_req_addr      (req_addr),
    .i_req_wdata     (req_wdata),
    .o_resp_valid    (resp_valid),
    .i_resp_ready    (resp_ready),
    .o_resp_is_write (resp_is_write),
    .o_resp_rdata    (resp_rdata)
`ifdef DMEM_LINE_SERVER_STATS_EN
    ,
    .o_stat_reads        (stat_reads),
    .o_stat_writes       (stat_writes),
    .o_stat_backpressure (stat_bp)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: latency, payload, stability under backpressure, ready rules.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      have_cur   = 1'b0;
    end else begin
      if (prev_hs) chk("req_ready_after_hs", 128'(req_ready), 128'd1);
      if (resp_valid) begin
        chk("req_ready_while_resp", 128'(req_ready), 128'd0);
        if (!resp_ready) m_bp++;
        if (!prev_valid) begin
          if (q.size() == 0) begin
            n_mis++;
            have_cur = 1'b0;
            $display("FAIL unexpected_resp: resp_valid=1 at cycle %0d with nothing pending", cyc);
          end else begin
            cur      = q.pop_front();
            have_cur = 1'b1;
            chk("resp_latency", 128'(cyc), 128'(cur.cyc));
          end
        end
        if (have_cur) begin
          chk("resp_is_write", 128'(resp_is_write), 128'(cur.we));
          if (cur.chk_data) chk("resp_rdata", resp_rdata, cur.data);
        end
      end
      prev_hs    = resp_valid && resp_ready;
      prev_valid = resp_valid;
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input line_t wd,
                       input logic chk_data, input line_t exp_data);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    @(negedge clk);
    chk("req_ready_at_accept", 128'(req_ready), 128'd1);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_mis++;
      $display("FAIL accept_timeout: req_ready=0 after %0d cycles, want 1", n);
    end
    e.we       = we;
    e.chk_data = we ? 1'b1 : chk_data;
    e.data     = we ? '0 : exp_data;
    e.cyc      = cyc + 1 + LAT;
    q.push_back(e);
    if (we) m_writes++; else m_reads++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = ~wd;
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((q.size() != 0 || resp_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || resp_valid) begin
      n_mis++;
      $display("FAIL drain_timeout: pending=%0d resp_valid=%0b, want 0 and 0", q.size(), resp_valid);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr, input line_t wd, input line_t exp_data);
    issue(we, addr, wd, 1'b1, exp_data);
    wait_drain();
  endtask

  localparam line_t W1 = 128'h4444_DDDD_3333_CCCC_2222_BBBB_1111_AAAA;
  localparam line_t W2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam line_t W3 = 128'hCAFE_0000_BEEF_1111_DEAD_2222_F00D_3333;
  localparam line_t W4 = 128'h5555_5555_AAAA_AAAA_5555_5555_AAAA_AAAA;
  localparam line_t W5 = 128'h9999_8888_7777_6666_5555_4444_3333_2222;
  localparam line_t W6 = 128'h8000_0001_4000_0002_2000_0004_1000_0008;
  localparam line_t Z  = '0;

  initial begin
    int n;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    m_reads = 0; m_writes = 0; m_bp = 0;

    @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 128'(req_ready), 128'd0);
    chk("rst_resp_valid", 128'(resp_valid), 128'd0);
    chk("rst_resp_is_write", 128'(resp_is_write), 128'd0);
    chk("rst_resp_rdata", resp_rdata, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_rst", 128'(req_ready), 128'd1);

    // Unwritten line: only timing and kind are known.
    issue(1'b0, 32'h0000_0040, Z, 1'b0, Z);
    wait_drain();

    xfer(1'b1, 32'h0000_0100, W1, Z);
    xfer(1'b0, 32'h0000_010C, Z, W1);
    xfer(1'b1, 32'h0000_0040, W2, Z);
    xfer(1'b0, 32'h0000_0044, Z, W2);

    // 0x4000 drops out of the 10-bit index and aliases line 0.
    xfer(1'b1, 32'h0000_4000, W3, Z);
    xfer(1'b0, 32'h0000_0000, Z, W3);
    xfer(1'b0, 32'h0000_0100, Z, W1);

    // Abort an uncommitted write with reset in its second BUSY cycle.
    xfer(1'b1, 32'h0000_0200, W4, Z);
    issue(1'b1, 32'h0000_0200, W5, 1'b1, Z);
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    m_reads = 0; m_writes = 0; m_bp = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_abort", 128'(req_ready), 128'd1);
    repeat (LAT + 3) @(negedge clk);
    xfer(1'b0, 32'h0000_0200, Z, W4);

    // Seven stalled cycles on a read response.
    resp_ready = 1'b0;
    issue(1'b0, 32'h0000_0108, Z, 1'b1, W1);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) begin
      n_mis++;
      $display("FAIL resp_timeout: resp_valid=0 after %0d cycles, want 1", n);
    end
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    wait_drain();

    xfer(1'b1, 32'h0000_3FF0, W6, Z);
    xfer(1'b0, 32'h0001_3FFC, Z, W6);

`ifdef DMEM_LINE_SERVER_STATS_EN
    chk("stat_reads", 128'(stat_reads), 128'(m_reads));
    chk("stat_writes", 128'(stat_writes), 128'(m_writes));
    chk("stat_backpressure", 128'(stat_bp), 128'(m_bp));
    chk("stat_bp_is_seven", 128'(stat_bp), 128'd7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/dmem_line_server.md
Name: dmem_line_server

Overview:
- Main-memory responder at the far end of the data-cache refill/writeback interface: the memory side that answers line requests issued by the data cache on a miss or eviction.
- Accepts one whole-line read or write per transaction, models a fixed access latency, then returns read data or a write acknowledge under a valid/ready handshake.
- Sits below the data cache, alongside the instruction memory.
- Backing store is a synthesizable line array.

Parameters:
LINE_WORDS, 4, 32-bit words per cache line (line = 128 bits at default)
DEPTH_LINES, 1024, number of lines in the backing store; power of two
LATENCY, 5, cycles from request accept to response valid; legal range 1..255

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  cache presents a request
req_ready  out  1  responder can accept a request this cycle
req_we  in  1  1 = line writeback, 0 = line refill read
req_addr  in  32  byte address; offset bits ignored
req_wdata  in  32*LINE_WORDS  writeback line, word 0 in bits [31:0]
resp_valid  out  1  response presented
resp_ready  in  1  cache consumes the response
resp_is_write  out  1  1 = write acknowledge, 0 = read data
resp_rdata  out  32*LINE_WORDS  refill line; 0 for write acks

Behaviour:
- Reset values: req_ready=0 during the reset cycle and 1 the cycle after; resp_valid=0, resp_is_write=0, resp_rdata=0, FSM=IDLE, counter=0. The backing store is not cleared by reset.
- Line index = req_addr[OFS +: log2(DEPTH_LINES)], where OFS = log2(4*LINE_WORDS). Higher address bits are dropped, so addresses wrap modulo the store size.
- FSM states IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch we, index and wdata; load the counter with LATENCY-1; go to BUSY.
  - Request inputs are sampled only at the accept edge; later changes are ignored.
- BUSY:
  - req_ready=0. The counter decrements each cycle.
  - When the counter is 0: a read loads resp_rdata from the array; a write commits the latched wdata to the array and sets resp_rdata=0.
  - Then go to RESP with resp_valid=1 and resp_is_write=we.
  - resp_valid rises exactly LATENCY cycles after the accept edge. LATENCY=1 means resp_valid in the very next cycle.
- RESP:
  - resp_valid, resp_is_write and resp_rdata are held stable until resp_ready=1.
  - On the handshake edge go to IDLE with resp_valid=0.
  - req_ready rises the cycle after the handshake: no accept in the same cycle as a response handshake, at most one outstanding transaction.
- Read-after-write to the same line returns the newly written data, because the write commits before its ack.
- resp_ready asserted while resp_valid=0 is ignored.
- reset asserted in BUSY or RESP aborts the transaction: the pending response is discarded. A write not yet committed is dropped; a committed write stays in the array.
- A LATENCY value outside the legal range must trip an elaboration-time $error.

Optional Feature:
- Macro: DMEM_LINE_SERVER_STATS_EN.
- When defined, add three 32-bit output ports, all cleared by reset and saturating at 2^32-1:
  - stat_reads: count of accepted reads
  - stat_writes: count of accepted writes
  - stat_backpressure: cycles with resp_valid=1 and resp_ready=0
- When undefined, those ports and counters do not exist and the behaviour is otherwise identical.

Decomposition:
- Shared package mem_pkg holds:
  - state enum dmem_state_t {IDLE, BUSY, RESP}
  - localparams for word width (32) and default LINE_WORDS
  - a line_t typedef for the packed line vector
- The data cache uses the same package so both ends agree on the line format.
- One natural sub-module: dmem_line_array, a single-port synchronous line store (index, we, wdata, rdata).
- The FSM, latency counter and handshake logic stay in the top.

Test Plan:
- Reset then read: assert reset 2 cycles; then req_valid=1, we=0, addr=0x0000_0040 -> req_ready=1 at accept, resp_valid rises exactly 5 cycles later, resp_is_write=0.
- Write then read: write addr 0x100, wdata=0xDDDD_CCCC_BBBB_AAAA_... (4 words), ack with resp_is_write=1 and rdata=0; read 0x10C -> same line returned, offset ignored.
- Backpressure: hold resp_ready=0 for 7 cycles -> resp_valid and rdata stable for all 7 cycles; req_ready=0 throughout; req_ready=1 one cycle after the handshake.
- Wrap-around: write index line via addr 0x0000_4000 with DEPTH_LINES=1024 (index 0) -> read of addr 0x0 returns the same line.
- Reset mid-op: accept a write to 0x200, assert reset in the 2nd BUSY cycle -> no resp_valid; a later read of 0x200 returns the old contents.
- LATENCY=1 build: a read accepted at edge N has resp_valid=1 after edge N+1; with DMEM_LINE_SERVER_STATS_EN defined, after 3 reads and 2 writes stat_reads=3 and stat_writes=2.
